// File: rtl/thor2023_pma_region_checker_if.sv
// MMU configuration bus bundle for the PMA region checker: a single-beat
// request/acknowledge bus with a 12-bit register address and 128-bit data.
interface thor2023_pma_region_checker_if;
    logic         cs;
    logic         req_cyc;
    logic         req_stb;
    logic         req_we;
    logic [11:0]  req_adr;
    logic [127:0] req_dat;
    logic         resp_ack;
    logic         resp_err;
    logic [127:0] resp_dat;

    modport master (
        output cs, req_cyc, req_stb, req_we, req_adr, req_dat,
        input  resp_ack, resp_err, resp_dat
    );

    modport slave (
        input  cs, req_cyc, req_stb, req_we, req_adr, req_dat,
        output resp_ack, resp_err, resp_dat
    );
endinterface

// File: rtl/thor2023_pma_region_checker.sv
// PMA region table with a two-stage address/permission checker. Optional
// per-region saturating hit counters are enabled by defining PMA_HIT_COUNT_EN.
module thor2023_pma_region_checker #(
    parameter int          NRGN     = 8,
    parameter int          ABITS    = 32,
    parameter logic [63:0] ROM_BASE = 64'hFFFC_0000
) (
    input  logic                                clk,
    input  logic                                rst,
    thor2023_pma_region_checker_if.slave        bus,
    input  logic                                chk_vld,
    input  logic [ABITS-1:0]                    chk_adr,
    input  logic [2:0]                          chk_acc,
    input  logic [1:0]                          chk_pl,
    output logic                                out_vld,
    output logic [3:0]                          out_rgn,
    output logic [31:0]                         out_attr,
    output logic [1:0]                          out_fault
);
    localparam int          RW       = $clog2(NRGN);
    localparam logic [31:0] LOCK_KEY = 32'h4C4F_434B;

    logic [ABITS-1:0] base_q  [NRGN];
    logic [ABITS-1:0] limit_q [NRGN];
    logic [31:0]      attr_q  [NRGN];
    logic [NRGN-1:0]  lock_q;
`ifdef PMA_HIT_COUNT_EN
    logic [31:0]      hit_q   [NRGN];
`endif

    logic [RW-1:0]  sel;
    logic [2:0]     field;
    logic           busy_q;
    logic           acc_req;
    logic           wr_req;
    logic           wr_ok;
    logic           wr_err;
    logic           hit_clr;
    logic [127:0]   rd_dat;
    logic           unused;

    assign sel     = bus.req_adr[8 +: RW];
    assign field   = bus.req_adr[6:4];
    // busy_q holds off a second ack until the master drops its strobe.
    assign acc_req = bus.cs & bus.req_cyc & bus.req_stb & ~bus.resp_ack & ~busy_q;
    assign wr_req  = acc_req & bus.req_we;
    assign unused  = ^{bus.req_adr, bus.req_dat};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        wr_ok   = 1'b0;
        hit_clr = 1'b0;
        if (wr_req) begin
`ifdef PMA_HIT_COUNT_EN
            hit_clr = (field == 3'd4);
`endif
            wr_ok = (field < 3'd4) && !lock_q[sel];
        end
        wr_err = wr_req & ~wr_ok & ~hit_clr;
    end

    always_comb begin
        rd_dat = '0;
        case (field)
            3'd0:    rd_dat[ABITS-1:0] = base_q[sel];
            3'd1:    rd_dat[ABITS-1:0] = limit_q[sel];
            3'd2:    rd_dat[31:0]      = attr_q[sel];
            3'd3:    rd_dat[0]         = lock_q[sel];
`ifdef PMA_HIT_COUNT_EN
            3'd4:    rd_dat[31:0]      = hit_q[sel];
`endif
            default: rd_dat = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the table is a small flop array with architecturally defined reset contents, so every entry is reset.
            for (int i = 0; i < NRGN; i++) begin
                base_q[i]  <= '0;
                limit_q[i] <= '0;
                attr_q[i]  <= '0;
            end
            base_q[NRGN-1]  <= ROM_BASE[ABITS-1:0];
            limit_q[NRGN-1] <= '1;
            attr_q[NRGN-1]  <= 32'h0000_DDDD;
            lock_q          <= '0;
            lock_q[NRGN-1]  <= 1'b1;
            busy_q          <= 1'b0;
            bus.resp_ack    <= 1'b0;
            bus.resp_err    <= 1'b0;
            bus.resp_dat    <= '0;
        end else begin
            busy_q       <= acc_req | (busy_q & bus.req_stb);
            bus.resp_ack <= acc_req;
            bus.resp_err <= wr_err;
            bus.resp_dat <= (acc_req && !bus.req_we) ? rd_dat : '0;
            if (wr_ok) begin
                case (field)
                    3'd0:    base_q[sel]  <= bus.req_dat[ABITS-1:0];
                    3'd1:    limit_q[sel] <= bus.req_dat[ABITS-1:0];
                    3'd2:    attr_q[sel]  <= bus.req_dat[31:0];
                    default: if (bus.req_dat[31:0] == LOCK_KEY) lock_q[sel] <= 1'b1;
                endcase
            end
        end
    end

    // Stage 1: range match against the table as it stood before this edge.
    logic            s1_vld;
    logic [NRGN-1:0] s1_m;
    logic [2:0]      s1_acc;
    logic [1:0]      s1_pl;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_vld <= 1'b0;
            s1_m   <= '0;
            s1_acc <= '0;
            s1_pl  <= '0;
        end else begin
            s1_vld <= chk_vld;
            s1_acc <= chk_acc;
            s1_pl  <= chk_pl;
            for (int i = 0; i < NRGN; i++)
                s1_m[i] <= (base_q[i] <= chk_adr) && (chk_adr <= limit_q[i]);
        end
    end

    logic [RW-1:0] win;
    logic          any_hit;
    logic [31:0]   win_attr;
    logic [2:0]    perm;
    logic [1:0]    fault_nxt;

    always_comb begin
        // NOTE: blocking assignments here so the descending loop leaves the lowest matching index in win.
        win = '0;
        for (int i = NRGN - 1; i >= 0; i--)
            if (s1_m[i]) win = RW'(i);
        any_hit  = |s1_m;
        win_attr = any_hit ? attr_q[win] : 32'd0;
        perm     = win_attr[{s1_pl, 2'b00} +: 3];
        if (!any_hit)                 fault_nxt = 2'd1;
        else if ((s1_acc & ~perm) != 3'd0) fault_nxt = 2'd2;
        else                          fault_nxt = 2'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_vld   <= 1'b0;
            out_rgn   <= '0;
            out_attr  <= '0;
            out_fault <= '0;
        end else begin
            out_vld   <= s1_vld;
            out_rgn   <= s1_vld ? 4'(win) : 4'd0;
            out_attr  <= s1_vld ? win_attr : 32'd0;
            out_fault <= s1_vld ? fault_nxt : 2'd0;
        end
    end

`ifdef PMA_HIT_COUNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NRGN; i++) hit_q[i] <= '0;
        end else begin
            for (int i = 0; i < NRGN; i++) begin
                if (hit_clr && sel == RW'(i))
                    hit_q[i] <= '0;
                else if (out_vld && out_fault != 2'd1 && out_rgn == 4'(i) && hit_q[i] != '1)
                    hit_q[i] <= hit_q[i] + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_thor2023_pma_region_checker.sv
// Scoreboard bench for the PMA region checker: a reference table model predicts
// each check result at issue time; a monitor pops and compares on out_vld.
module tb_thor2023_pma_region_checker;
    localparam int          NRGN     = 8;
    localparam logic [31:0] LOCK_KEY = 32'h4C4F_434B;
`ifdef PMA_HIT_COUNT_EN
    localparam bit HIT_EN = 1'b1;
`else
    localparam bit HIT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        chk_vld = 1'b0;
    logic [31:0] chk_adr = '0;
    logic [2:0]  chk_acc = '0;
    logic [1:0]  chk_pl  = '0;
    logic        out_vld;
    logic [3:0]  out_rgn;
    logic [31:0] out_attr;
    logic [1:0]  out_fault;

    thor2023_pma_region_checker_if bus();

    thor2023_pma_region_checker dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .chk_vld   (chk_vld),
        .chk_adr   (chk_adr),
        .chk_acc   (chk_acc),
        .chk_pl    (chk_pl),
        .out_vld   (out_vld),
        .out_rgn   (out_rgn),
        .out_attr  (out_attr),
        .out_fault (out_fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int          due;
        logic [3:0]  rgn;
        logic [31:0] attr;
        logic [1:0]  fault;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          passed = 0;
    int          total  = 0;

    logic [31:0] m_base  [NRGN];
    logic [31:0] m_limit [NRGN];
    logic [31:0] m_attr  [NRGN];
    bit          m_lock  [NRGN];
    logic [31:0] m_hits  [NRGN];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NRGN; i++) begin
            m_base[i] = '0; m_limit[i] = '0; m_attr[i] = '0; m_lock[i] = 1'b0; m_hits[i] = '0;
        end
        m_base[NRGN-1]  = 32'hFFFC_0000;
        m_limit[NRGN-1] = 32'hFFFF_FFFF;
        m_attr[NRGN-1]  = 32'h0000_DDDD;
        m_lock[NRGN-1]  = 1'b1;
    endfunction

    // First region (in index order) whose inclusive range holds adr decides the result.
    function automatic exp_t predict(input logic [31:0] adr, input logic [2:0] acc, input logic [1:0] pl);
        exp_t e;
        int   nib;
        e.due = cyc + 2; e.rgn = '0; e.attr = '0; e.fault = 2'd1;
        for (int i = 0; i < NRGN; i++) begin
            if (adr >= m_base[i] && adr <= m_limit[i]) begin
                nib     = int'((m_attr[i] >> (4 * int'(pl))) & 32'h7);
                e.rgn   = 4'(i);
                e.attr  = m_attr[i];
                e.fault = ((int'(acc) & ~nib & 7) != 0) ? 2'd2 : 2'd0;
                return e;
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (out_vld) begin
            if (sb.size() == 0) begin
                check("unexpected_out_vld", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("out_latency", cyc, mon_e.due);
                check("out_rgn", out_rgn, mon_e.rgn);
                check("out_attr", out_attr, mon_e.attr);
                check("out_fault", out_fault, mon_e.fault);
                if (mon_e.fault != 2'd1 && m_hits[mon_e.rgn] != 32'hFFFF_FFFF)
                    m_hits[mon_e.rgn] = m_hits[mon_e.rgn] + 1;
            end
        end
    end

    task automatic drive_chk(input logic [31:0] adr, input logic [2:0] acc, input logic [1:0] pl);
        chk_vld = 1'b1; chk_adr = adr; chk_acc = acc; chk_pl = pl;
        sb.push_back(predict(adr, acc, pl));
    endtask

    task automatic check_one(input logic [31:0] adr, input logic [2:0] acc, input logic [1:0] pl);
        drive_chk(adr, acc, pl);
        @(negedge clk);
        chk_vld = 1'b0;
    endtask

    task automatic bus_xfer(input bit we, input int rgn, input int fld, input logic [127:0] wdat,
                            output logic [127:0] rdat, output logic err);
        int n = 0;
        bus.cs = 1'b1; bus.req_cyc = 1'b1; bus.req_stb = 1'b1; bus.req_we = we;
        bus.req_adr = 12'((rgn << 8) | (fld << 4)); bus.req_dat = wdat;
        do begin @(negedge clk); n++; end while (!bus.resp_ack && n < 8);
        check("ack_latency", n, 1);
        rdat = bus.resp_dat; err = bus.resp_err;
        bus.cs = 1'b0; bus.req_cyc = 1'b0; bus.req_stb = 1'b0; bus.req_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic bus_write(input int rgn, input int fld, input logic [127:0] d);
        logic [127:0] r;
        logic         err, exp_err;
        exp_err = (fld >= 5) || (fld == 4 && !HIT_EN) || (fld < 4 && m_lock[rgn]);
        bus_xfer(1'b1, rgn, fld, d, r, err);
        check($sformatf("wr_err r%0d f%0d", rgn, fld), err, exp_err);
        if (!exp_err) begin
            case (fld)
                0: m_base[rgn]  = d[31:0];
                1: m_limit[rgn] = d[31:0];
                2: m_attr[rgn]  = d[31:0];
                3: if (d[31:0] == LOCK_KEY) m_lock[rgn] = 1'b1;
                default: m_hits[rgn] = '0;
            endcase
        end
    endtask

    task automatic bus_read(input int rgn, input int fld);
        logic [127:0] r, exp_r;
        logic         err;
        case (fld)
            0: exp_r = 128'(m_base[rgn]);
            1: exp_r = 128'(m_limit[rgn]);
            2: exp_r = 128'(m_attr[rgn]);
            3: exp_r = 128'(m_lock[rgn]);
            4: exp_r = HIT_EN ? 128'(m_hits[rgn]) : 128'd0;
            default: exp_r = '0;
        endcase
        bus_xfer(1'b0, rgn, fld, '0, r, err);
        check($sformatf("rd r%0d f%0d", rgn, fld), r, exp_r);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n_high;
        logic [31:0] b, l, a;
        int          j, pt;
        bus.cs = 1'b0; bus.req_cyc = 1'b0; bus.req_stb = 1'b0; bus.req_we = 1'b0;
        bus.req_adr = '0; bus.req_dat = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst out_vld", out_vld, 0);
        check("rst out_fault", {out_rgn, out_attr, out_fault}, 0);
        check("rst resp", {bus.resp_ack, bus.resp_err, bus.resp_dat}, 0);
        rst = 1'b1;
        @(negedge clk);

        // Held strobe: exactly one ack pulse, read data only alongside it.
        bus.cs = 1'b1; bus.req_cyc = 1'b1; bus.req_stb = 1'b1; bus.req_we = 1'b0;
        bus.req_adr = 12'h700;
        @(negedge clk);
        check("ack_first", bus.resp_ack, 1);
        check("rd r7 base held", bus.resp_dat, 128'hFFFC_0000);
        n_high = 0;
        repeat (3) begin @(negedge clk); n_high += int'(bus.resp_ack); end
        check("ack_single_pulse", n_high, 0);
        check("resp_dat_idle", bus.resp_dat, 0);
        bus.cs = 1'b0; bus.req_cyc = 1'b0; bus.req_stb = 1'b0;
        @(negedge clk);
        for (int f = 1; f < 4; f++) bus_read(7, f);
        for (int f = 0; f < 4; f++) bus_read(0, f);

        bus_write(1, 0, 32'h1000_0000);
        bus_write(1, 1, 32'h1FFF_FFFF);
        bus_write(1, 2, 32'h0000_FFFF);
        check_one(32'h1800_0000, 3'b100, 2'd0);
        check_one(32'h0800_0000, 3'b100, 2'd0);
        check_one(32'hFFFC_0010, 3'b010, 2'd3);
        repeat (3) @(negedge clk);

        bus_write(1, 3, LOCK_KEY);
        bus_read(1, 3);
        bus_write(1, 0, 32'h0);
        bus_read(1, 0);
        bus_write(1, 3, 32'h0);
        bus_read(1, 3);
        bus_write(7, 2, 32'h0);
        bus_write(2, 5, 32'h1);
        bus_write(2, 3, 32'h123);
        bus_read(2, 3);
        do_reset();
        bus_read(1, 3);
        bus_read(1, 0);

        bus_write(0, 0, 32'h1000_0000);
        bus_write(0, 1, 32'h1FFF_FFFF);
        bus_write(0, 2, 32'h0000_7777);
        bus_write(1, 0, 32'h1800_0000);
        bus_write(1, 1, 32'h2FFF_FFFF);
        bus_write(1, 2, 32'h0000_FFFF);
        check_one(32'h1800_0000, 3'b111, 2'd2);
        drive_chk(32'h1800_0000, 3'b100, 2'd1); @(negedge clk);
        drive_chk(32'h2800_0000, 3'b111, 2'd0); @(negedge clk);
        drive_chk(32'h3000_0000, 3'b001, 2'd2); @(negedge clk);
        drive_chk(32'hFFFF_FFF0, 3'b001, 2'd3); @(negedge clk);
        chk_vld = 1'b0;
        repeat (3) @(negedge clk);

        // Same-cycle write and check: first check sees the old base, the next the new.
        bus.cs = 1'b1; bus.req_cyc = 1'b1; bus.req_stb = 1'b1; bus.req_we = 1'b1;
        bus.req_adr = 12'h000; bus.req_dat = 128'h2000_0000;
        drive_chk(32'h1800_0000, 3'b100, 2'd0);
        @(negedge clk);
        check("same_cycle ack", {bus.resp_ack, bus.resp_err}, 2'b10);
        m_base[0] = 32'h2000_0000;
        bus.cs = 1'b0; bus.req_cyc = 1'b0; bus.req_stb = 1'b0; bus.req_we = 1'b0;
        drive_chk(32'h1800_0000, 3'b100, 2'd0);
        @(negedge clk);
        chk_vld = 1'b0;
        repeat (3) @(negedge clk);

        bus_write(1, 4, 32'h0);
        repeat (3) check_one(32'h2800_0000, 3'b100, 2'd0);
        repeat (4) @(negedge clk);
        bus_read(1, 4);
        bus_write(1, 4, 32'h5);
        bus_read(1, 4);

        for (int r = 0; r < NRGN - 1; r++) begin
            b = $urandom;
            l = ($urandom_range(0, 3) == 0) ? b - $urandom_range(1, 1000) : b + $urandom_range(0, 32'h0FFF_FFFF);
            a = $urandom;
            bus_write(r, 0, b);
            bus_write(r, 1, l);
            bus_write(r, 2, a);
        end
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) != 0) begin
                j  = $urandom_range(0, NRGN - 1);
                pt = $urandom_range(0, 4);
                case (pt)
                    0: a = m_base[j];
                    1: a = m_limit[j];
                    2: a = m_base[j] - 1;
                    3: a = m_limit[j] + 1;
                    default: a = $urandom;
                endcase
                drive_chk(a, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
            end else begin
                chk_vld = 1'b0;
            end
            @(negedge clk);
        end
        chk_vld = 1'b0;
        repeat (4) @(negedge clk);

        // Reset while a check sits in stage 1: it must never emerge.
        chk_vld = 1'b1; chk_adr = 32'hFFFC_0000; chk_acc = 3'b100; chk_pl = 2'd0;
        @(negedge clk);
        chk_vld = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("flush out_vld", out_vld, 0);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        check("flush out_vld next", out_vld, 0);
        bus_read(0, 0);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
